// File: rtl/fp_conv_pkg.sv
// Shared types and constants for the float-to-fixed converter.
// Holds the FSM state encoding, IEEE-754 single field positions and
// saturation constants used by the converter and its unpack helper.
package fp_conv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLASSIFY,
    ST_SHIFT,
    ST_NEGATE,
    ST_OUT
  } state_t;

  localparam int          BIAS    = 127;
  localparam logic [7:0]  EXP_INF = 8'd255;
  localparam int          MANT_W  = 24;

  localparam logic [31:0] SAT_POS = 32'h7FFF_FFFF;
  localparam logic [31:0] SAT_NEG = 32'h8000_0000;

  // IEEE-754 single-precision field positions
  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int FRAC_MSB = 22;
  localparam int FRAC_LSB = 0;

endpackage

// File: rtl/fp_to_fixed_converter_if.sv
// Handshake bundle between multiplier source, converter and fixed-point sink.
// Input side: fpIn/fpReady/fpAccept. Output side: intOut/intReady/intAccepted
// plus overflow/invalid/inexact flags. slave = converter view, master = environment.
interface fp_to_fixed_converter_if;
  logic [31:0] fpIn;
  logic        fpReady;
  logic        fpAccept;
  logic [31:0] intOut;
  logic        intReady;
  logic        intAccepted;
  logic        overflow;
  logic        invalid;
  logic        inexact;

  modport slave (
    input  fpIn, fpReady, intAccepted,
    output fpAccept, intOut, intReady, overflow, invalid, inexact
  );

  modport master (
    output fpIn, fpReady, intAccepted,
    input  fpAccept, intOut, intReady, overflow, invalid, inexact
  );
endinterface

// File: rtl/fp_unpack.sv
// Combinational split of an IEEE-754 single into sign, exponent, mantissa.
// Latency: zero (pure combinational).
// Ports: fp in; sign/exp_f/frac/mant fields and is_nan/is_inf/is_zero_denorm out.
module fp_unpack
  import fp_conv_pkg::*;
(
  input  logic [31:0]       fp,
  output logic              sign,
  output logic [7:0]        exp_f,
  output logic [22:0]       frac,
  output logic [MANT_W-1:0] mant,
  output logic              is_nan,
  output logic              is_inf,
  output logic              is_zero_denorm
);

  assign sign           = fp[SIGN_BIT];
  assign exp_f          = fp[EXP_MSB:EXP_LSB];
  assign frac           = fp[FRAC_MSB:FRAC_LSB];
  // hidden bit is present only for normal numbers
  assign mant           = {exp_f != 8'd0, frac};
  assign is_nan         = (exp_f == EXP_INF) && (frac != 23'd0);
  assign is_inf         = (exp_f == EXP_INF) && (frac == 23'd0);
  assign is_zero_denorm = (exp_f == 8'd0);

endmodule

// File: rtl/fp_to_fixed_converter.sv
// IEEE-754 single to signed Q(31-FRAC_BITS).FRAC_BITS, truncate toward zero, saturating.
// Latency: 2+n cycles from capture (n = |e-23| single-bit shifts), 2 for special/zero cases.
// Backpressure: one operand in flight; fpAccept only in IDLE, result held in OUT until intAccepted.
// Ports: clk, rst (async active-low), bus (slave modport of fp_to_fixed_converter_if).
module fp_to_fixed_converter
  import fp_conv_pkg::*;
#(
  parameter int FRAC_BITS = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  fp_to_fixed_converter_if.slave        bus
);

  state_t state, state_nxt;

  logic [31:0] op_q;
  logic [31:0] shifter;
  logic [4:0]  count;
  logic        shift_left;
  logic        special;
  logic [31:0] int_q;
  logic        ovf_q, inv_q, inx_q;

  logic              u_sign;
  logic [7:0]        u_exp;
  logic [22:0]       u_frac;
  logic [MANT_W-1:0] u_mant;
  logic              u_nan, u_inf, u_zd;

  fp_unpack u_unpack (
    .fp             (op_q),
    .sign           (u_sign),
    .exp_f          (u_exp),
    .frac           (u_frac),
    .mant           (u_mant),
    .is_nan         (u_nan),
    .is_inf         (u_inf),
    .is_zero_denorm (u_zd)
  );

  // e: position of the hidden bit in the fixed-point result
  logic signed [9:0] e_exp, e_rel;
  logic [4:0]        n_amt;
  logic              ovf_fin, zero_res, normal;

  assign e_exp = $signed({2'b00, u_exp}) - 10'(BIAS) + 10'(FRAC_BITS);
  assign e_rel = e_exp - 10'sd23;
  assign n_amt = 5'(e_rel[9] ? -e_rel : e_rel);

  // e==31 fits only for exactly -2^31
  assign ovf_fin  = (e_exp > 10'sd31) ||
                    ((e_exp == 10'sd31) && !(u_sign && (u_frac == 23'd0)));
  assign zero_res = u_zd || e_exp[9];
  assign normal   = !u_nan && !u_inf && !ovf_fin && !zero_res;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Special cases still pass through NEGATE (as a no-op) so every result
  // costs at least two cycles after capture.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (bus.fpReady) state_nxt = ST_CLASSIFY;
      ST_CLASSIFY: state_nxt = (normal && (n_amt != 5'd0)) ? ST_SHIFT : ST_NEGATE;
      ST_SHIFT:    if (count == 5'd1) state_nxt = ST_NEGATE;
      ST_NEGATE:   state_nxt = ST_OUT;
      ST_OUT:      if (bus.intAccepted) state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q       <= 32'd0;
      shifter    <= 32'd0;
      count      <= 5'd0;
      shift_left <= 1'b0;
      special    <= 1'b0;
      int_q      <= 32'd0;
      ovf_q      <= 1'b0;
      inv_q      <= 1'b0;
      inx_q      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.fpReady) begin
            op_q  <= bus.fpIn;
            ovf_q <= 1'b0;
            inv_q <= 1'b0;
            inx_q <= 1'b0;
          end
        end
        ST_CLASSIFY: begin
          special    <= 1'b1;
          shifter    <= 32'd0;
          count      <= 5'd0;
          shift_left <= 1'b0;
          int_q      <= 32'd0;
          if (u_nan) begin
            inv_q <= 1'b1;
            int_q <= SAT_POS;
          end else if (u_inf || ovf_fin) begin
            ovf_q <= 1'b1;
            int_q <= u_sign ? SAT_NEG : SAT_POS;
          end else if (zero_res) begin
            inx_q <= (u_mant != '0);
          end else begin
            special    <= 1'b0;
            shifter    <= {8'd0, u_mant};
            count      <= n_amt;
            shift_left <= !e_rel[9];
          end
        end
        ST_SHIFT: begin
          count <= count - 5'd1;
          if (shift_left) begin
            shifter <= shifter << 1;
          end else begin
            shifter <= shifter >> 1;
            if (shifter[0]) inx_q <= 1'b1;
          end
        end
        ST_NEGATE: begin
          // -(2^31) wraps to itself, which is the correct result
          if (!special) int_q <= u_sign ? -shifter : shifter;
        end
        default: ;
      endcase
    end
  end

  assign bus.fpAccept = (state == ST_IDLE);
  assign bus.intReady = (state == ST_OUT);
  assign bus.intOut   = int_q;
  assign bus.overflow = ovf_q;
  assign bus.invalid  = inv_q;
  assign bus.inexact  = inx_q;

endmodule

// File: tb/tb_fp_to_fixed_converter.sv
// Self-checking bench for fp_to_fixed_converter with a queue scoreboard.
// Directed vectors carry constant expectations; random vectors use a reference model.
// Also covers OUT-state hold under source activity and asynchronous reset mid-shift.
module tb_fp_to_fixed_converter;
  localparam int FRAC_BITS = 8;
  localparam logic [31:0] SATP = 32'h7FFF_FFFF;
  localparam logic [31:0] SATN = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fp_to_fixed_converter_if bus();

  fp_to_fixed_converter #(.FRAC_BITS(FRAC_BITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] op;
    logic [31:0] val;
    logic [2:0]  flg;   // {overflow, invalid, inexact}
    int          lat;
    int          cap;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc   = 0;
  logic rdy_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] op, input logic [31:0] val,
                              input logic [2:0] flg, input int lat);
    exp_t r;
    r.op = op; r.val = val; r.flg = flg; r.lat = lat; r.cap = 0;
    return r;
  endfunction

  // Reference: value * 2^FRAC_BITS = m * 2^sh, evaluated in 64-bit arithmetic
  function automatic exp_t model(input logic [31:0] fp);
    exp_t   r;
    int     ex, sh;
    longint m, mag, v;
    logic   inx;
    r.op = fp; r.val = '0; r.flg = '0; r.lat = 2; r.cap = 0; inx = 1'b0;
    ex = int'(fp[30:23]);
    if (ex == 255) begin
      if (fp[22:0] != 23'd0) begin r.flg = 3'b010; r.val = SATP; end
      else begin r.flg = 3'b100; r.val = fp[31] ? SATN : SATP; end
      return r;
    end
    if (ex == 0) begin
      r.flg = {2'b00, fp[22:0] != 23'd0};
      return r;
    end
    m  = longint'({1'b1, fp[22:0]});
    sh = ex - 150 + FRAC_BITS;
    if (sh > 30) mag = 64'sd1 <<< 40;
    else if (sh >= 0) mag = m <<< sh;
    else if (sh < -40) begin mag = 0; inx = 1'b1; end
    else begin
      mag = m >>> (-sh);
      inx = (m & ((64'sd1 <<< (-sh)) - 64'sd1)) != 64'sd0;
    end
    v = fp[31] ? -mag : mag;
    if (v > 64'sd2147483647 || v < -64'sd2147483648) begin
      r.flg = 3'b100;
      r.val = fp[31] ? SATN : SATP;
    end else begin
      r.val = v[31:0];
      r.flg = {2'b00, inx};
      if (mag != 0) r.lat = 2 + ((sh < 0) ? -sh : sh);
    end
    return r;
  endfunction

  // Monitor: compare each new result against the scoreboard head
  always @(negedge clk) begin
    if (bus.intReady && !rdy_prev) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_output", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        chk($sformatf("%h value", mon_e.op), bus.intOut, mon_e.val);
        chk($sformatf("%h flags", mon_e.op),
            {29'd0, bus.overflow, bus.invalid, bus.inexact}, {29'd0, mon_e.flg});
        chk($sformatf("%h latency", mon_e.op), 32'(cyc - mon_e.cap), 32'(mon_e.lat));
      end
    end
    rdy_prev = bus.intReady;
  end

  // wait_acc < 0 leaves the result sitting in OUT
  task automatic send(input exp_t e, input int wait_acc);
    int t;
    @(negedge clk);
    bus.fpIn    = e.op;
    bus.fpReady = 1'b1;
    t = 0;
    while (!bus.fpAccept && t < 50) begin @(negedge clk); t++; end
    if (!bus.fpAccept) begin
      chk("accept_timeout", 32'd0, 32'd1);
      bus.fpReady = 1'b0;
      return;
    end
    e.cap = cyc + 1;
    sb_q.push_back(e);
    @(posedge clk); #1;
    bus.fpReady = 1'b0;
    bus.fpIn    = $urandom;
    t = 0;
    while (!bus.intReady && t < 60) begin @(negedge clk); t++; end
    if (!bus.intReady) begin
      chk("ready_timeout", 32'd0, 32'd1);
      return;
    end
    if (wait_acc < 0) return;
    repeat (wait_acc) @(negedge clk);
    bus.intAccepted = 1'b1;
    @(posedge clk); #1;
    bus.intAccepted = 1'b0;
  endtask

  exp_t dir_q[$];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    logic [31:0] rfp;
    bus.fpIn = 32'd0; bus.fpReady = 1'b0; bus.intAccepted = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset intReady", {31'd0, bus.intReady}, 32'd0);
    chk("reset intOut", bus.intOut, 32'd0);
    chk("reset flags", {29'd0, bus.overflow, bus.invalid, bus.inexact}, 32'd0);
    chk("reset fpAccept", {31'd0, bus.fpAccept}, 32'd1);
    rst = 1'b1;

    dir_q.push_back(mk(32'hC122_0000, 32'hFFFF_F5E0, 3'b000, 14));
    dir_q.push_back(mk(32'h3F80_0001, 32'h0000_0100, 3'b001, 17));
    dir_q.push_back(mk(32'hCB00_0000, 32'h8000_0000, 3'b000, 10));
    dir_q.push_back(mk(32'h4F00_0000, 32'h7FFF_FFFF, 3'b100, 2));
    dir_q.push_back(mk(32'hFF80_0000, 32'h8000_0000, 3'b100, 2));
    dir_q.push_back(mk(32'h7FC0_0000, 32'h7FFF_FFFF, 3'b010, 2));
    dir_q.push_back(mk(32'h0000_0001, 32'h0000_0000, 3'b001, 2));
    dir_q.push_back(mk(32'h8000_0000, 32'h0000_0000, 3'b000, 2));
    dir_q.push_back(mk(32'h3FC0_0000, 32'h0000_0180, 3'b000, 17));
    dir_q.push_back(mk(32'h4300_0000, 32'h0000_8000, 3'b000, 10));
    dir_q.push_back(mk(32'h4B00_0000, 32'h7FFF_FFFF, 3'b100, 2));
    dir_q.push_back(mk(32'h3B80_0000, 32'h0000_0001, 3'b000, 25));
    dir_q.push_back(mk(32'h3B00_0000, 32'h0000_0000, 3'b001, 2));
    dir_q.push_back(mk(32'h4700_0000, 32'h0080_0000, 3'b000, 2));
    dir_q.push_back(mk(32'hC700_0000, 32'hFF80_0000, 3'b000, 2));

    foreach (dir_q[i]) send(dir_q[i], i % 3);

    for (int i = 0; i < 20; i++) begin
      rfp = {1'($urandom), 8'($urandom_range(100, 165)), 23'($urandom)};
      send(model(rfp), i % 2);
    end

    // Hold in OUT while the source keeps toggling
    send(mk(32'h4120_0000, 32'h0000_0A00, 3'b000, 14), -1);
    for (int i = 0; i < 5; i++) begin
      bus.fpReady = ~bus.fpReady;
      bus.fpIn    = $urandom;
      @(negedge clk);
      chk("hold intOut", bus.intOut, 32'h0000_0A00);
      chk("hold flags", {29'd0, bus.overflow, bus.invalid, bus.inexact}, 32'd0);
      chk("hold intReady", {31'd0, bus.intReady}, 32'd1);
      chk("hold fpAccept", {31'd0, bus.fpAccept}, 32'd0);
    end
    bus.fpReady = 1'b0;
    bus.intAccepted = 1'b1;
    @(posedge clk); #1;
    bus.intAccepted = 1'b0;
    chk("release fpAccept", {31'd0, bus.fpAccept}, 32'd1);
    chk("release intReady", {31'd0, bus.intReady}, 32'd0);
    chk("release intOut kept", bus.intOut, 32'h0000_0A00);

    // Asynchronous reset in the middle of the shift phase
    @(negedge clk);
    bus.fpIn = 32'hC122_0000;
    bus.fpReady = 1'b1;
    begin
      int t;
      t = 0;
      while (!bus.fpAccept && t < 50) begin @(negedge clk); t++; end
      chk("rst_case accept", {31'd0, bus.fpAccept}, 32'd1);
    end
    @(posedge clk); #1;
    bus.fpReady = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("async rst intReady", {31'd0, bus.intReady}, 32'd0);
    chk("async rst intOut", bus.intOut, 32'd0);
    chk("async rst fpAccept", {31'd0, bus.fpAccept}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    send(mk(32'hC122_0000, 32'hFFFF_F5E0, 3'b000, 14), 1);
    send(model(32'h4049_0FDB), 0);

    repeat (3) @(negedge clk);
    chk("scoreboard empty", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/fp_to_fixed_converter.md
Name: fp_to_fixed_converter

Overview:
- Downstream consumer of the floating-point multiplier. Takes its IEEE-754 single-precision result over a ready/accept handshake.
- Converts the value to signed 32-bit two's-complement fixed point with FRAC_BITS fraction bits, truncating toward zero and saturating on overflow.
- Iterative: a one-bit-per-cycle barrel-free shifter FSM, so latency depends on the exponent.
- Result goes out on a second ready/accept handshake toward the display/accumulator side.

Parameters:
FRAC_BITS, 8, number of fraction bits in intOut (Q(31-FRAC_BITS).FRAC_BITS); legal range 0..30

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
fpIn  input  32  IEEE-754 single operand (multiplier result)
fpReady  input  1  source has valid fpIn (multiplier resultReady)
fpAccept  output  1  block is idle and takes fpIn this edge (to multiplier resultAccepted)
intOut  output  32  signed fixed-point result
intReady  output  1  intOut/flags valid
intAccepted  input  1  sink consumed intOut
overflow  output  1  result saturated (finite out of range or Inf)
invalid  output  1  operand was NaN
inexact  output  1  nonzero bits were discarded by truncation

Behaviour:
- Reset: rst low asynchronously forces state IDLE. It also forces intOut=0, intReady=0 and all flags 0. Reset mid-operation abandons the operand with no output.
- fpAccept = (state==IDLE), Moore. Capture happens on the edge where fpReady&&fpAccept. fpIn is ignored at all other times.
- States: IDLE, CLASSIFY, SHIFT, NEGATE, OUT.
- IDLE -> CLASSIFY on capture (call this edge k). Latch sign s, exponent E and mantissa M={E!=0,frac}. Clear flags.
- CLASSIFY (edge k+1): compute e = E-127+FRAC_BITS (signed, 10 bits). Then:
  - E==255 and frac!=0: invalid=1, intOut=0x7FFFFFFF, go to OUT.
  - E==255 and frac==0: overflow=1, intOut=0x7FFFFFFF (s=0) or 0x80000000 (s=1), go to OUT.
  - e>31, or e==31 and not (s==1 and frac==0): overflow=1, saturate by sign, go to OUT.
  - E==0 or e<0: intOut=0, inexact=(M!=0) with no hidden bit, go to OUT.
  - Otherwise: load shifter with M zero-extended, set count n=|e-23| and direction (left if e>23). Go to SHIFT if n>0, else NEGATE.
- SHIFT: one bit per edge, count decrements. On a right shift a 1 leaving bit0 sets the inexact sticky bit. Go to NEGATE when the count reaches 1 on that edge.
- NEGATE (one edge): intOut = s ? -shifter : shifter, then OUT. The -2^31 case wraps correctly to 0x80000000.
- Latency, normal path: intReady is high after edge k+2+n. Special cases: after edge k+2.
- OUT: intReady=1. intOut and flags are held stable until intAccepted is sampled high, then go to IDLE with intReady=0. Flags and intOut keep their values until the next CLASSIFY.
- intAccepted outside OUT is ignored. fpReady outside IDLE is ignored, so the source must hold fpReady/fpIn until fpAccept.
- Back-to-back: earliest next capture is one cycle after leaving OUT.

Decomposition:
- Package fp_conv_pkg holds:
  - state enum
  - BIAS=127, EXP_INF=255, MANT_W=24
  - SAT_POS=32'h7FFFFFFF, SAT_NEG=32'h80000000
  - IEEE field index constants
- Optional sub-module fp_unpack (combinational: sign/exp/mant split, isNaN/isInf/isZeroDenorm). The FSM and shifter stay in the top.

Test Plan:
- fpIn=0xC1220000 (-10.125), FRAC_BITS=8, fpReady held until fpAccept -> intOut=0xFFFFF5E0 (-2592), all flags 0, intReady rises 14 cycles after capture (n=12).
- fpIn=0x3F800001, FRAC_BITS=8 -> intOut=0x00000100, inexact=1 (n=15 right shifts). Then fpIn=0xCB000000 -> intOut=0x80000000, overflow=0 (n=8 left shifts).
- fpIn=0x4F000000, FRAC_BITS=8 -> intOut=0x7FFFFFFF, overflow=1, intReady 2 cycles after capture. Then fpIn=0xFF800000 -> 0x80000000, overflow=1.
- fpIn=0x7FC00000 -> invalid=1, intOut=0x7FFFFFFF. Then fpIn=0x00000001 -> intOut=0, inexact=1. Then fpIn=0x80000000 -> intOut=0, inexact=0.
- Hold intAccepted low 5 cycles in OUT while toggling fpReady/fpIn -> intOut, flags and intReady stable, fpAccept=0, no capture. Pulse intAccepted -> IDLE next edge.
- Assert rst low mid-SHIFT of the -10.125 case, asynchronously between edges -> immediately intReady=0, intOut=0, fpAccept=1. After release a new operand converts correctly.
